// File: rtl/addsub_acc4.sv
// rtl/addsub_acc4.sv - burst add/subtract accumulator behind the 4-bit ripple adder/subtractor
// Optional saturation on signed overflow: define ACC_SAT_EN.
module addsub_acc4 #(
   parameter int WIDTH = 4,
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sub,
   output logic [WIDTH-1:0] acc_out,
   output logic             carry_out,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [LEN_W-1:0] count;
   logic [WIDTH-1:0] acc_q;
   logic             carry_q;
   logic             ovf_q;

   logic             accept;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH:0]   sum;
   logic             beat_ovf;
   logic [WIDTH-1:0] acc_nxt;

   assign accept   = in_valid && in_ready;
   // Subtract as add of the inverted operand with carry-in = in_sub.
   assign b_op     = in_sub ? ~in_data : in_data;
   assign sum      = {1'b0, acc_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, in_sub};
   assign beat_ovf = (acc_q[MSB] == b_op[MSB]) && (sum[MSB] != acc_q[MSB]);

`ifdef ACC_SAT_EN
   always_comb begin
      acc_nxt = sum[MSB:0];
      if (beat_ovf) begin
         acc_nxt = acc_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      end
   end
`else
   assign acc_nxt = sum[MSB:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (len != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (accept && (count == LEN_W'(1))) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == S_RUN);
      busy     = (state == S_RUN);
      done     = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         count   <= '0;
      end else if ((state == S_IDLE) && start) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         count   <= len;
      end else if (accept) begin
         acc_q   <= acc_nxt;
         carry_q <= sum[WIDTH];
         ovf_q   <= ovf_q | beat_ovf;
         count   <= count - LEN_W'(1);
      end
   end

   assign acc_out   = acc_q;
   assign carry_out = carry_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_acc4.sv
// tb/tb_addsub_acc4.sv - scoreboard bench for addsub_acc4
// Expected values follow the ACC_SAT_EN build setting.
module tb_addsub_acc4;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] len;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_sub;
   logic [3:0] acc_out;
   logic       carry_out;
   logic       ovf;
   logic       busy;
   logic       done;

   addsub_acc4 #(.WIDTH(4), .LEN_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sub    (in_sub),
      .acc_out   (acc_out),
      .carry_out (carry_out),
      .ovf       (ovf),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       is_done;
      logic [3:0] acc;
      logic       carry;
      logic       ovf;
   } exp_t;

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   logic pending = 1'b0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: got event with no expectation, expected none", name);
   endtask

   task automatic push(input logic d, input logic [3:0] a, input logic c, input logic o);
      exp_t e;
      e.is_done = d;
      e.acc     = a;
      e.carry   = c;
      e.ovf     = o;
      q.push_back(e);
   endtask

   // Monitor: results of an accepted beat are compared one cycle later, done pulses as they appear.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pending = 1'b0;
            continue;
         end
         if (pending) begin
            pending = 1'b0;
            if (q.size() == 0) fail_now("beat_unexpected");
            else begin
               e = q.pop_front();
               check("beat_kind", {7'd0, e.is_done}, 8'd0);
               check("beat_acc", {4'd0, acc_out}, {4'd0, e.acc});
               check("beat_carry", {7'd0, carry_out}, {7'd0, e.carry});
               check("beat_ovf", {7'd0, ovf}, {7'd0, e.ovf});
            end
            if (q.size() != 0 && q[0].is_done) check("done_timing", {7'd0, done}, 8'd1);
         end
         if (done) begin
            if (q.size() == 0) fail_now("done_unexpected");
            else begin
               e = q.pop_front();
               check("done_kind", {7'd0, e.is_done}, 8'd1);
               check("done_acc", {4'd0, acc_out}, {4'd0, e.acc});
               check("done_carry", {7'd0, carry_out}, {7'd0, e.carry});
               check("done_ovf", {7'd0, ovf}, {7'd0, e.ovf});
               check("done_busy", {7'd0, busy}, 8'd0);
            end
         end
         if (in_valid && in_ready) pending = 1'b1;
      end
   end

   task automatic do_start(input logic [2:0] l);
      start = 1'b1;
      len   = l;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic beat(input logic [3:0] d, input logic s);
      in_valid = 1'b1;
      in_data  = d;
      in_sub   = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 4'b1111;
      in_sub   = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, {7'd0, seen}, 8'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      len      = 3'd0;
      in_valid = 1'b0;
      in_data  = 4'd0;
      in_sub   = 1'b0;
      idle(2);
      check("rst_acc", {4'd0, acc_out}, 8'd0);
      check("rst_carry", {7'd0, carry_out}, 8'd0);
      check("rst_ovf", {7'd0, ovf}, 8'd0);
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_done", {7'd0, done}, 8'd0);
      check("rst_ready", {7'd0, in_ready}, 8'd0);
      rst_n = 1'b1;
      idle(1);

      // add then subtract
      push(0, 4'b1011, 0, 0);
      push(0, 4'b0010, 1, 0);
      push(1, 4'b0010, 1, 0);
      do_start(3'd2);
      beat(4'b1011, 1'b0);
      beat(4'b1001, 1'b1);
      wait_done("addsub_done");

      // signed overflow
`ifdef ACC_SAT_EN
      push(0, 4'b0111, 0, 0);
      push(0, 4'b0111, 0, 1);
      push(0, 4'b0111, 0, 1);
      push(1, 4'b0111, 0, 1);
`else
      push(0, 4'b0111, 0, 0);
      push(0, 4'b1000, 0, 1);
      push(0, 4'b1001, 0, 1);
      push(1, 4'b1001, 0, 1);
`endif
      do_start(3'd3);
      beat(4'b0111, 1'b0);
      beat(4'b0001, 1'b0);
      beat(4'b0001, 1'b0);
      wait_done("ovf_done");

      // zero-length burst
      push(1, 4'b0000, 0, 0);
      do_start(3'd0);
      @(negedge clk);
      check("zero_done", {7'd0, done}, 8'd1);
      check("zero_ready", {7'd0, in_ready}, 8'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("zero_ready_after", {7'd0, in_ready}, 8'd0);
      @(posedge clk);
      #1;

      // stall between beats
      push(0, 4'b0011, 0, 0);
      push(0, 4'b0111, 0, 0);
      push(1, 4'b0111, 0, 0);
      do_start(3'd2);
      beat(4'b0011, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_hold", {4'd0, acc_out}, 8'h03);
         @(posedge clk);
         #1;
      end
      beat(4'b0100, 1'b0);
      wait_done("stall_done");

      // start while busy is ignored
      push(0, 4'b0001, 0, 0);
      push(0, 4'b0010, 0, 0);
      push(0, 4'b0011, 0, 0);
      push(1, 4'b0011, 0, 0);
      do_start(3'd3);
      beat(4'b0001, 1'b0);
      start = 1'b1;
      len   = 3'd5;
      idle(1);
      start = 1'b0;
      beat(4'b0001, 1'b0);
      beat(4'b0001, 1'b0);
      wait_done("busy_start_done");
      @(negedge clk);
      check("busy_after_done", {7'd0, busy}, 8'd0);
      @(posedge clk);
      #1;

      // reset mid-burst
      push(0, 4'b0101, 0, 0);
      do_start(3'd3);
      beat(4'b0101, 1'b0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_acc", {4'd0, acc_out}, 8'd0);
      check("midrst_busy", {7'd0, busy}, 8'd0);
      check("midrst_ready", {7'd0, in_ready}, 8'd0);
      check("midrst_ovf", {7'd0, ovf}, 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      check("midrst_idle", {7'd0, busy | done}, 8'd0);
      push(0, 4'b0010, 0, 0);
      push(1, 4'b0010, 0, 0);
      do_start(3'd1);
      beat(4'b0010, 1'b0);
      wait_done("fresh_done");

      idle(3);
      check("queue_empty", 8'(q.size()), 8'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
